// File: rtl/instruction_package.sv
// Shared definitions for the regex instruction executor.
//   opcode_t               : 3-bit instruction opcode (top bits of the word)
//   INSTRUCTION_DATA_WIDTH : width of the operand field (low bits of the word)
//   state_t                : executor FSM states
package instruction_package;

  localparam int OPCODE_WIDTH           = 3;
  localparam int INSTRUCTION_DATA_WIDTH = 13;

  typedef enum logic [OPCODE_WIDTH-1:0] {
    ACCEPT                = 3'd0,
    SPLIT                 = 3'd1,
    MATCH                 = 3'd2,
    JMP                   = 3'd3,
    END_WITHOUT_ACCEPTING = 3'd4,
    MATCH_ANY             = 3'd5,
    ACCEPT_PARTIAL        = 3'd6,
    NOT_MATCH             = 3'd7
  } opcode_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT_DATA,
    S_EXEC,
    S_EMIT
  } state_t;

endpackage

// File: rtl/regex_cpu.sv
// Single-thread regex instruction executor.
// Takes one (pc, cc_id) thread, fetches its instruction, evaluates it against
// the selected window character and either emits successor threads or
// updates the acceptance flag.
// Ports:
//   clk, rst                                   clock, synchronous active-high reset
//   current_characters, end_of_string          shared character window and end flags
//   input_pc_valid/ready, input_pc, input_cc_id   incoming thread
//   memory_valid/ready, memory_addr, memory_data  instruction fetch
//   output_pc_valid/ready, output_pc, output_cc_id successor threads
//   accepts                                    registered acceptance flag
//
// state       | meaning
// S_IDLE      | ready for a new thread
// S_FETCH     | fetch request outstanding
// S_WAIT_DATA | instruction word arrives this cycle
// S_EXEC      | decode and evaluate instruction
// S_EMIT      | presenting successor thread(s)
module regex_cpu
  import instruction_package::*;
#(
  parameter int PC_WIDTH          = 9,
  parameter int CC_ID_BITS        = 2,
  parameter int CHARACTER_WIDTH   = 8,
  parameter int MEMORY_WIDTH      = 16,
  parameter int MEMORY_ADDR_WIDTH = 11
) (
  input  logic                                          clk,
  input  logic                                          rst,
  input  logic [(2**CC_ID_BITS)*CHARACTER_WIDTH-1:0]    current_characters,
  input  logic [2**CC_ID_BITS-1:0]                      end_of_string,
  input  logic                                          input_pc_valid,
  output logic                                          input_pc_ready,
  input  logic [CC_ID_BITS-1:0]                         input_cc_id,
  input  logic [PC_WIDTH-1:0]                           input_pc,
  output logic                                          memory_valid,
  input  logic                                          memory_ready,
  output logic [MEMORY_ADDR_WIDTH-1:0]                  memory_addr,
  input  logic [MEMORY_WIDTH-1:0]                       memory_data,
  output logic                                          output_pc_valid,
  input  logic                                          output_pc_ready,
  output logic [CC_ID_BITS-1:0]                         output_cc_id,
  output logic [PC_WIDTH-1:0]                           output_pc,
  output logic                                          accepts
);

  state_t state, state_nxt;

  logic [PC_WIDTH-1:0]     pc_q;
  logic [CC_ID_BITS-1:0]   cc_q;
  logic [MEMORY_WIDTH-1:0] instr_q;
  logic [PC_WIDTH-1:0]     out_pc_q;
  logic [CC_ID_BITS-1:0]   out_cc_q;
  logic                    second_pending_q;
  logic                    accepts_q;

  logic [CHARACTER_WIDTH-1:0]        chars [2**CC_ID_BITS];
  opcode_t                           opcode;
  logic [INSTRUCTION_DATA_WIDTH-1:0] data;
  logic [CHARACTER_WIDTH-1:0]        ch;
  logic                              eos;
  logic                              ch_eq;
  logic [PC_WIDTH-1:0]               pc_inc;
  logic [PC_WIDTH-1:0]               target;
  logic [CC_ID_BITS-1:0]             cc_inc;
  logic                              exec_emit;
  logic                              exec_split;
  logic [PC_WIDTH-1:0]               exec_pc;
  logic [CC_ID_BITS-1:0]             exec_cc;
  logic                              exec_acc_we;
  logic                              exec_acc_val;
  logic                              unused_data;

  for (genvar i = 0; i < 2**CC_ID_BITS; i++) begin : g_chars
    assign chars[i] = current_characters[i*CHARACTER_WIDTH +: CHARACTER_WIDTH];
  end

  assign opcode = opcode_t'(instr_q[MEMORY_WIDTH-1 -: OPCODE_WIDTH]);
  assign data   = instr_q[INSTRUCTION_DATA_WIDTH-1:0];
  assign ch     = chars[cc_q];
  assign eos    = end_of_string[cc_q];
  assign ch_eq  = (ch == data[CHARACTER_WIDTH-1:0]);
  assign pc_inc = pc_q + PC_WIDTH'(1);
  assign cc_inc = cc_q + CC_ID_BITS'(1);
  assign target = data[PC_WIDTH-1:0];
  // Operand bits above the pc width carry no meaning for this configuration.
  assign unused_data = ^data[INSTRUCTION_DATA_WIDTH-1:PC_WIDTH];

  // Instruction evaluation; only consumed while in S_EXEC.
  always_comb begin
    exec_emit    = 1'b0;
    exec_split   = 1'b0;
    exec_pc      = pc_inc;
    exec_cc      = cc_q;
    exec_acc_we  = 1'b0;
    exec_acc_val = 1'b0;
    case (opcode)
      ACCEPT: begin
        exec_acc_we  = 1'b1;
        exec_acc_val = eos;
      end
      ACCEPT_PARTIAL: begin
        exec_acc_we  = 1'b1;
        exec_acc_val = 1'b1;
      end
      END_WITHOUT_ACCEPTING: ;
      MATCH: begin
        exec_emit = !eos && ch_eq;
        exec_cc   = cc_inc;
      end
      NOT_MATCH: begin
        exec_emit = !eos && !ch_eq;
        exec_cc   = cc_inc;
      end
      MATCH_ANY: begin
        exec_emit = !eos;
        exec_cc   = cc_inc;
      end
      JMP: begin
        exec_emit = 1'b1;
        exec_pc   = target;
      end
      SPLIT: begin
        exec_emit  = 1'b1;
        exec_split = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt       = state;
    input_pc_ready  = 1'b0;
    memory_valid    = 1'b0;
    output_pc_valid = 1'b0;
    case (state)
      S_IDLE: begin
        input_pc_ready = 1'b1;
        if (input_pc_valid) state_nxt = S_FETCH;
      end
      S_FETCH: begin
        memory_valid = 1'b1;
        if (memory_ready) state_nxt = S_WAIT_DATA;
      end
      S_WAIT_DATA: state_nxt = S_EXEC;
      S_EXEC:      state_nxt = exec_emit ? S_EMIT : S_IDLE;
      S_EMIT: begin
        output_pc_valid = 1'b1;
        if (output_pc_ready && !second_pending_q) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q             <= '0;
      cc_q             <= '0;
      instr_q          <= '0;
      out_pc_q         <= '0;
      out_cc_q         <= '0;
      second_pending_q <= 1'b0;
      accepts_q        <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (input_pc_valid) begin
            pc_q      <= input_pc;
            cc_q      <= input_cc_id;
            accepts_q <= 1'b0;
          end
        end
        S_WAIT_DATA: instr_q <= memory_data;
        S_EXEC: begin
          if (exec_acc_we) accepts_q <= exec_acc_val;
          out_pc_q         <= exec_pc;
          out_cc_q         <= exec_cc;
          second_pending_q <= exec_split;
        end
        S_EMIT: begin
          // SPLIT: after pc+1 is taken, present the branch target with the same slot.
          if (output_pc_ready && second_pending_q) begin
            out_pc_q         <= target;
            second_pending_q <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign memory_addr  = MEMORY_ADDR_WIDTH'(pc_q);
  assign output_pc    = out_pc_q;
  assign output_cc_id = out_cc_q;
  assign accepts      = accepts_q;

endmodule

// File: tb/tb_regex_cpu.sv
module tb_regex_cpu;

  localparam int PCW = 9;
  localparam int CCB = 2;
  localparam int CW  = 8;
  localparam int MW  = 16;
  localparam int MAW = 11;
  localparam int NS  = 4;

  localparam logic [2:0] OP_ACCEPT  = 3'd0;
  localparam logic [2:0] OP_SPLIT   = 3'd1;
  localparam logic [2:0] OP_MATCH   = 3'd2;
  localparam logic [2:0] OP_JMP     = 3'd3;
  localparam logic [2:0] OP_ANY     = 3'd5;
  localparam logic [2:0] OP_PARTIAL = 3'd6;
  localparam logic [2:0] OP_NOT     = 3'd7;

  typedef struct {int pc; int cc;} thr_t;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [NS*CW-1:0] current_characters = '0;
  logic [NS-1:0]    end_of_string = '0;
  logic             input_pc_valid = 1'b0;
  logic             input_pc_ready;
  logic [CCB-1:0]   input_cc_id = '0;
  logic [PCW-1:0]   input_pc = '0;
  logic             memory_valid;
  logic             memory_ready = 1'b0;
  logic [MAW-1:0]   memory_addr;
  logic [MW-1:0]    memory_data = '0;
  logic             output_pc_valid;
  logic             output_pc_ready = 1'b0;
  logic [CCB-1:0]   output_cc_id;
  logic [PCW-1:0]   output_pc;
  logic             accepts;

  always #5 clk = ~clk;

  regex_cpu #(
    .PC_WIDTH(PCW), .CC_ID_BITS(CCB), .CHARACTER_WIDTH(CW),
    .MEMORY_WIDTH(MW), .MEMORY_ADDR_WIDTH(MAW)
  ) dut (
    .clk(clk), .rst(rst),
    .current_characters(current_characters), .end_of_string(end_of_string),
    .input_pc_valid(input_pc_valid), .input_pc_ready(input_pc_ready),
    .input_cc_id(input_cc_id), .input_pc(input_pc),
    .memory_valid(memory_valid), .memory_ready(memory_ready),
    .memory_addr(memory_addr), .memory_data(memory_data),
    .output_pc_valid(output_pc_valid), .output_pc_ready(output_pc_ready),
    .output_cc_id(output_cc_id), .output_pc(output_pc),
    .accepts(accepts)
  );

  // Reference: what one thread must produce, from the instruction rules.
  function automatic void model(input int pc, input int cc, input logic [15:0] word,
                                input logic [31:0] chars, input logic [3:0] eos_v,
                                output int n, output thr_t t0, output thr_t t1, output bit acc);
    int op, data, ch;
    bit eos, hit;
    op   = int'(word[15:13]);
    data = int'(word[12:0]);
    ch   = int'((chars >> (cc * CW)) & 32'hFF);
    eos  = eos_v[cc];
    n = 0; acc = 1'b0; t0 = '{0, 0}; t1 = '{0, 0};
    case (op)
      0: acc = eos;
      6: acc = 1'b1;
      2, 5, 7: begin
        hit = (op == 5) || ((op == 2) == (ch == (data % 256)));
        if (!eos && hit) begin n = 1; t0 = '{(pc + 1) % 512, (cc + 1) % 4}; end
      end
      3: begin n = 1; t0 = '{data % 512, cc}; end
      1: begin n = 2; t0 = '{(pc + 1) % 512, cc}; t1 = '{data % 512, cc}; end
      default: ;
    endcase
  endfunction

  // Monitor-owned state
  int   tests = 0, fails = 0;
  int   n_started = 0, n_done = 0, mem_hs_cnt = 0, timeouts_seen = 0;
  bit   in_txn = 0, mem_done = 0, cur_acc = 0, pinned = 0;
  bit   busy_exec, exp_mv, exp_ov, exp_rdy;
  int   since = 0, exp_addr = 0;
  thr_t q[$];

  // Driver-owned state
  int   pend_n = 0, pend_pc = 0, timeouts = 0;
  thr_t pend_t0, pend_t1;
  bit   pend_acc = 0;
  logic [15:0] cur_word = '0;
  int   mem_seen = 0;

  task automatic chk(input string nm, input int got, input int exp);
    tests++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, got, exp, $time);
    end
  endtask

  task automatic pin_model();
    int n; thr_t a, b; bit acc;
    logic [31:0] ch3a;
    ch3a = {8'h61, 8'h10, 8'h20, 8'h30};
    model(5, 3, {OP_MATCH, 13'h61}, ch3a, 4'b0000, n, a, b, acc);
    chk("pin_match_n", n, 1); chk("pin_match_pc", a.pc, 6); chk("pin_match_cc", a.cc, 0);
    model(5, 3, {OP_MATCH, 13'h62}, ch3a, 4'b0000, n, a, b, acc);
    chk("pin_mismatch_n", n, 0); chk("pin_mismatch_acc", int'(acc), 0);
    model(5, 3, {OP_NOT, 13'h62}, ch3a, 4'b0000, n, a, b, acc);
    chk("pin_not_match_n", n, 1);
    model(10, 1, {OP_SPLIT, 13'd40}, ch3a, 4'b0000, n, a, b, acc);
    chk("pin_split_n", n, 2); chk("pin_split_pc0", a.pc, 11); chk("pin_split_pc1", b.pc, 40);
    chk("pin_split_cc1", b.cc, 1);
    model(100, 2, {OP_JMP, 13'd7}, ch3a, 4'b0000, n, a, b, acc);
    chk("pin_jmp_pc", a.pc, 7); chk("pin_jmp_cc", a.cc, 2);
    model(511, 3, {OP_ANY, 13'd0}, ch3a, 4'b0000, n, a, b, acc);
    chk("pin_wrap_pc", a.pc, 0); chk("pin_wrap_cc", a.cc, 0);
    model(0, 0, {OP_ACCEPT, 13'd0}, ch3a, 4'b0001, n, a, b, acc);
    chk("pin_accept_eos", int'(acc), 1);
    model(0, 0, {OP_ACCEPT, 13'd0}, ch3a, 4'b0000, n, a, b, acc);
    chk("pin_accept_noeos", int'(acc), 0);
  endtask

  // Per-cycle compare, sampled mid-cycle; inputs change just after posedge.
  always @(negedge clk) begin
    if (!pinned) begin
      pinned = 1;
      pin_model();
    end
    if (timeouts != timeouts_seen) begin
      tests++;
      fails++;
      timeouts_seen = timeouts;
    end
    if (rst) begin
      in_txn = 0; mem_done = 0; since = 0; cur_acc = 0;
      q.delete();
    end else begin
      if (in_txn && mem_done) since++;
      busy_exec = in_txn && !(mem_done && since >= 3);
      exp_mv    = in_txn && !mem_done;
      exp_ov    = in_txn && !busy_exec && q.size() > 0;
      exp_rdy   = !in_txn || (!busy_exec && q.size() == 0);
      chk("memory_valid", int'(memory_valid), int'(exp_mv));
      chk("input_pc_ready", int'(input_pc_ready), int'(exp_rdy));
      chk("output_pc_valid", int'(output_pc_valid), int'(exp_ov));
      chk("accepts", int'(accepts), busy_exec ? 0 : int'(cur_acc));
      if (exp_mv && memory_valid) chk("memory_addr", int'(memory_addr), exp_addr);
      if (exp_ov && output_pc_valid) begin
        chk("output_pc", int'(output_pc), q[0].pc);
        chk("output_cc_id", int'(output_cc_id), q[0].cc);
      end
      if (exp_mv && memory_valid && memory_ready) begin
        mem_done = 1; since = 0; mem_hs_cnt++;
      end
      if (exp_ov && output_pc_valid && output_pc_ready) void'(q.pop_front());
      if (in_txn && exp_rdy) begin
        in_txn = 0;
        n_done++;
      end else if (!in_txn && input_pc_valid && input_pc_ready) begin
        in_txn = 1; mem_done = 0; since = 0;
        exp_addr = pend_pc;
        cur_acc  = pend_acc;
        q.delete();
        if (pend_n > 0) q.push_back(pend_t0);
        if (pend_n > 1) q.push_back(pend_t1);
        n_started++;
      end
    end
  end

  // Memory responds with the word only in the cycle after the fetch handshake.
  always @(posedge clk) begin
    #1;
    if (mem_hs_cnt != mem_seen) begin
      memory_data = cur_word;
      mem_seen    = mem_hs_cnt;
    end else begin
      memory_data = MW'($urandom);
    end
  end

  task automatic run_txn(input int pc, input int cc, input logic [15:0] word,
                         input logic [31:0] chars, input logic [3:0] eos,
                         input int stall, input bit rnd);
    int s0, d0, stall_left;
    bit started, done;
    model(pc, cc, word, chars, eos, pend_n, pend_t0, pend_t1, pend_acc);
    pend_pc = pc;
    @(posedge clk); #1;
    current_characters = chars;
    end_of_string      = eos;
    input_pc           = PCW'(pc);
    input_cc_id        = CCB'(cc);
    cur_word           = word;
    input_pc_valid     = 1'b1;
    memory_ready       = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    output_pc_ready    = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    s0 = n_started; d0 = n_done; stall_left = stall; started = 0; done = 0;
    for (int k = 0; k < 300 && !done; k++) begin
      @(posedge clk); #1;
      if (!started && n_started != s0) begin
        started        = 1;
        input_pc_valid = 1'b0;
        input_pc       = PCW'($urandom);
        input_cc_id    = CCB'($urandom);
      end
      if (started && n_done != d0) done = 1;
      memory_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (stall_left > 0) begin
        output_pc_ready = 1'b0;
        if (output_pc_valid) stall_left--;
      end else begin
        output_pc_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      end
    end
    if (!done) begin
      $display("FAIL txn_timeout: pc %0d word %h got no completion, expected within 300 cycles", pc, word);
      timeouts++;
      input_pc_valid = 1'b0;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
    end
  endtask

  task automatic reset_in_fetch();
    int s0;
    model(33, 1, {OP_ACCEPT, 13'd0}, 32'h0, 4'b0000, pend_n, pend_t0, pend_t1, pend_acc);
    pend_pc = 33;
    @(posedge clk); #1;
    input_pc = PCW'(33); input_cc_id = CCB'(1); cur_word = {OP_ACCEPT, 13'd0};
    input_pc_valid = 1'b1; memory_ready = 1'b0;
    s0 = n_started;
    for (int k = 0; k < 20 && n_started == s0; k++) begin
      @(posedge clk); #1;
    end
    input_pc_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    memory_ready = 1'b1;
    repeat (3) @(posedge clk);
  endtask

  function automatic logic [31:0] rand_chars(input int lo, input int hi);
    logic [31:0] c;
    for (int s = 0; s < NS; s++) c[s*CW +: CW] = CW'($urandom_range(lo, hi));
    return c;
  endfunction

  initial begin
    logic [31:0] ch;
    logic [15:0] w;
    int cc;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    for (int pc = 0; pc < 255; pc++)
      run_txn(pc, 0, {OP_ACCEPT, 13'd0}, rand_chars(1, 254), 4'b0001, 0, 0);
    for (int pc = 0; pc < 255; pc++)
      run_txn(pc, 0, {OP_ACCEPT, 13'd0}, rand_chars(1, 254), 4'b0000, 0, 0);
    for (int c = 0; c < 255; c++) begin
      ch = {4{8'(c)}};
      run_txn(c, c % 4, {OP_PARTIAL, 13'd0}, ch, 4'b0000, 0, 0);
    end

    ch = {8'h61, 8'h10, 8'h20, 8'h30};
    run_txn(5, 3, {OP_MATCH, 13'h61}, ch, 4'b0000, 0, 0);
    run_txn(5, 3, {OP_MATCH, 13'h62}, ch, 4'b0000, 0, 0);
    run_txn(5, 3, {OP_NOT, 13'h62}, ch, 4'b0000, 0, 0);
    run_txn(5, 3, {OP_MATCH, 13'h61}, ch, 4'b1000, 0, 0);
    run_txn(10, 2, {OP_SPLIT, 13'd40}, ch, 4'b0000, 3, 0);
    run_txn(20, 1, {OP_JMP, 13'd7}, ch, 4'b0000, 0, 0);
    run_txn(511, 3, {OP_ANY, 13'd0}, ch, 4'b0000, 0, 0);
    run_txn(511, 0, {OP_SPLIT, 13'h1FF}, ch, 4'b0000, 2, 0);
    reset_in_fetch();
    run_txn(6, 0, {OP_ACCEPT, 13'd0}, ch, 4'b0001, 0, 0);

    for (int i = 0; i < 400; i++) begin
      w  = 16'($urandom);
      cc = $urandom_range(0, 3);
      ch = rand_chars(0, 255);
      if ($urandom_range(0, 1) == 1) ch[cc*CW +: CW] = w[7:0];
      run_txn($urandom_range(0, 511), cc, w, ch, 4'($urandom), $urandom_range(0, 3), 1);
    end

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/regex_cpu.md
Name: regex_cpu

Overview:
Single-thread regex instruction executor inside a CICERO-style engine. It accepts one (pc, character-window id) thread and fetches that instruction from instruction memory. It decodes the instruction against the selected character of a small character window and then either emits successor threads or flags acceptance. Several instances share the window and memory arbiter.

Parameters:
PC_WIDTH, 9, program counter width.
CC_ID_BITS, 2, log2 of the number of characters in the window.
CHARACTER_WIDTH, 8, bits per character.
MEMORY_WIDTH, 16, instruction word width.
MEMORY_ADDR_WIDTH, 11, instruction memory address width; the pc is zero-extended to this width.

Ports:
clk  in  1  clock
rst  in  1  reset
current_characters  in  (2**CC_ID_BITS)*CHARACTER_WIDTH  character window; character i is bits [i*CHARACTER_WIDTH +: CHARACTER_WIDTH]
end_of_string  in  2**CC_ID_BITS  bit i set when window slot i is past the string end
input_pc_valid / input_pc_ready  in / out  1  thread input handshake
input_cc_id  in  CC_ID_BITS  window slot of the incoming thread
input_pc  in  PC_WIDTH  incoming thread pc
memory_valid / memory_ready  out / in  1  fetch request handshake
memory_addr  out  MEMORY_ADDR_WIDTH  fetch address
memory_data  in  MEMORY_WIDTH  instruction word, valid the cycle after the request handshake
output_pc_valid / output_pc_ready  out / in  1  successor-thread handshake
output_cc_id  out  CC_ID_BITS  successor window slot
output_pc  out  PC_WIDTH  successor pc
accepts  out  1  acceptance flag

Behaviour:
- One clock; reset is synchronous and active-high (clk, rst). After reset the block is in IDLE:
  - input_pc_ready=1
  - memory_valid=0
  - output_pc_valid=0
  - accepts=0
- All handshakes transfer on a clock edge where valid and ready are both high.
- Instruction word format: opcode is bits [MEMORY_WIDTH-1 -: 3]; data is the low INSTRUCTION_DATA_WIDTH=13 bits.
- Jump and split targets are data[PC_WIDTH-1:0].
- FSM: IDLE -> FETCH -> WAIT_DATA -> EXEC -> IDLE or EMIT.
- IDLE:
  - input_pc_ready=1.
  - On input handshake, latch pc and cc_id, clear accepts, go to FETCH.
  - input_pc_ready drops on the next cycle.
- FETCH:
  - memory_valid=1 and memory_addr=zero-extended pc, held stable until memory_ready.
  - On handshake go to WAIT_DATA; memory_valid=0 from the next cycle.
- WAIT_DATA: register memory_data; go to EXEC.
- EXEC, by opcode. Let ch = selected character and eos = end_of_string[cc_id].
  - ACCEPT=0: accepts<=eos; go to IDLE.
  - ACCEPT_PARTIAL=6: accepts<=1; go to IDLE.
  - END_WITHOUT_ACCEPTING=4: go to IDLE.
  - MATCH=2: if !eos and ch==data[CHARACTER_WIDTH-1:0], emit (pc+1, cc_id+1); else go to IDLE.
  - NOT_MATCH=7: same as MATCH with the compare inverted.
  - MATCH_ANY=5: if !eos, emit (pc+1, cc_id+1).
  - JMP=3: emit (target, cc_id).
  - SPLIT=1: emit (pc+1, cc_id), then (target, cc_id).
- EMIT:
  - output_pc_valid=1 with output_pc and output_cc_id held stable until output_pc_ready.
  - For SPLIT, stay in EMIT for the second thread after the first handshake.
  - After the last handshake, go to IDLE.
- Total from memory handshake to input_pc_ready=1 for accept-type opcodes: 2 cycles.
- accepts is registered and holds its value until the next input handshake clears it.
- Arithmetic wraps modulo the field width:
  - pc+1 wraps modulo 2**PC_WIDTH.
  - cc_id+1 wraps modulo 2**CC_ID_BITS.
- Inputs are ignored outside their state: input_pc_valid outside IDLE, memory_data outside WAIT_DATA, output_pc_ready outside EMIT.
- rst in any state forces IDLE and the reset output values on the next edge.

Decomposition:
- instruction_package holds:
  - opcode enum: ACCEPT, SPLIT, MATCH, JMP, END_WITHOUT_ACCEPTING, MATCH_ANY, ACCEPT_PARTIAL, NOT_MATCH
  - INSTRUCTION_DATA_WIDTH=13
  - opcode width 3
- The block is a single module; no sub-module.

Test Plan:
- For each pc in 0..254, chars 1..254 in all slots, end_of_string=4'b0001, cc_id=0, memory word {ACCEPT,13'b0} -> memory_addr==pc; accepts==1 two edges after the data edge.
- Same with end_of_string=0 -> accepts==0; input_pc_ready back to 1 within 2 cycles.
- {ACCEPT_PARTIAL,0} with any char 0..254 and end_of_string=0 -> accepts==1.
- pc=5, cc_id=3, slot 3='a', MATCH 'a', output_pc_ready=1 -> one output (pc=6, cc_id=0); MATCH 'b' -> no output, accepts=0.
- SPLIT target 40 at pc=10, output_pc_ready held low for 3 cycles -> output (11,cc) stays stable, then (40,cc), then IDLE; JMP 7 -> (7,cc).
- rst asserted during FETCH -> memory_valid=0, input_pc_ready=1 next cycle.
